wifi_rts_in: RTL
================

WIFI_RTS_IN -- requirements
Module: wifi_rts_in

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of flip-flops in the input synchronizer (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable cycles required to accept a level change (legal range 1..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port address, input, 2 bits: Avalon-MM slave word address.
REQ-006 SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 SHALL have port writedata, input, 32 bits: write data.
REQ-009 SHALL have port in_port, input, 1 bit: asynchronous WIFI_RTS pin from the Wi-Fi module.
REQ-010 SHALL have port readdata, output, 32 bits: read data.
REQ-011 SHALL have port irq, output, 1 bit: active-high level interrupt.

Function
REQ-012 SHALL sample in_port through a SYNC_STAGES-deep flip-flop chain; its last stage is "s".
REQ-013 SHALL keep a debounced level "lvl" and a 16-bit counter "cnt".
- cnt clears whenever s equals lvl.
- cnt increments each cycle s differs from lvl.
REQ-014 SHALL, on an edge where s differs from lvl and cnt equals DEBOUNCE_CYCLES-1, load lvl with s and clear cnt.
REQ-015 SHALL ignore any excursion of s that is shorter than DEBOUNCE_CYCLES cycles: lvl is unchanged and cnt returns to 0.
REQ-016 SHALL update lvl SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples a new stable in_port value.
REQ-017 SHALL keep a 2-bit register cfg selecting which edges qualify.
- 00: both edges.
- 01: rising only.
- 10: falling only.
- 11: none.
REQ-018 SHALL set edgecapture bit0 on the same edge that lvl changes, when that change qualifies under cfg.
REQ-019 SHALL keep edgecapture set until software clears it.
REQ-020 SHALL give set priority over clear when a qualifying edge and a clear write occur in the same cycle.
REQ-021 SHALL keep a 1-bit register irqmask.
REQ-022 SHALL drive irq = edgecapture AND irqmask, as pure logic of registered state.
REQ-023 SHALL use this register map (write = chipselect AND NOT write_n):
- addr 0: read {31'b0, lvl}; writes ignored.
- addr 1: read {30'b0, cfg}; write loads cfg from writedata[1:0].
- addr 2: read {31'b0, irqmask}; write loads irqmask from writedata[0].
- addr 3: read {31'b0, edgecapture}; write with writedata[0]=1 clears edgecapture, with writedata[0]=0 has no effect.
REQ-024 SHALL drive readdata combinationally from address (zero wait states), independent of chipselect; unused bits read 0.
REQ-025 SHALL NOT let a cfg change alter existing edgecapture contents; the change affects only subsequent edges.
REQ-026 SHALL hold lvl and cnt across register writes; only a debounced input change or reset alters them.

Reset
REQ-027 SHALL, while reset_n is low, clear synchronizer stages, lvl, cnt, cfg, irqmask and edgecapture to 0.
REQ-028 SHALL force irq=0 and readdata bit0 at addr 0 to 0 during reset.
REQ-029 SHALL, when reset asserts mid-debounce, discard the pending count; counting restarts from 0 after release.
REQ-030 SHALL, if in_port is high at reset release, report it as a rising edge after SYNC_STAGES+DEBOUNCE_CYCLES cycles.

Verification
REQ-031 Bench SHALL cover, with SYNC_STAGES=2 and DEBOUNCE_CYCLES=4: in_port 0->1 before edge 1 -> lvl=1 and edgecapture=1 after edge 6, not after edge 5.
REQ-032 Bench SHALL cover: 3-cycle high glitch on s -> lvl stays 0, edgecapture stays 0, cnt back to 0.
REQ-033 Bench SHALL cover: cfg=01, irqmask=1, in_port 1->0 -> edgecapture=0, irq=0; then 0->1 -> irq=1; write addr 3 data 1 -> irq=0 next cycle.
REQ-034 Bench SHALL cover: clear write to addr 3 on the same edge that lvl changes (cfg=00) -> edgecapture reads 1 afterwards.
REQ-035 Bench SHALL cover: reset_n low for 1 cycle at cnt=2 with in_port high -> all registers 0; after release lvl rises 6 edges later and edgecapture=1.
REQ-036 Bench SHALL cover: reads of addr 0..3 after writing 0xFFFFFFFF to addr 1 and addr 2 -> 0x0000000X values with bits 31..2 zero, cfg=3, irqmask=1.

Source files
------------

// File: rtl/wifi_rts_in.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wifi_rts_in
// Brief    : Avalon-MM input port for the Wi-Fi module RTS pin. Synchronizes
//            and debounces the pin, captures qualifying edges into a sticky
//            edgecapture bit and raises a masked level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module wifi_rts_in #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  // Count value on which a persistent difference is accepted as the new level.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_q, lvl_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [1:0]             cfg_q, cfg_d;
  logic                   irqmask_q, irqmask_d;
  logic                   edgecap_q, edgecap_d;

  logic s;
  logic lvl_chg;
  logic edge_qual;
  logic wr_en;
  logic wdata_unused;

  // Only writedata[1:0] carry register content; the rest are don't-care.
  assign wdata_unused = ^writedata[31:2];

  assign s     = sync_q[SYNC_STAGES-1];
  assign wr_en = chipselect & ~write_n;

  // Shift the raw pin into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
  end

  // Debounce: accept s only after it has differed from lvl for DEBOUNCE_CYCLES edges.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    lvl_chg = 1'b0;
    if (s == lvl_q) begin
      cnt_d = 16'd0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d   = s;
      cnt_d   = 16'd0;
      lvl_chg = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Decide whether the current level change is one cfg asks us to capture.
  always_comb begin
    edge_qual = 1'b0;
    unique case (cfg_q)
      2'b00:   edge_qual = lvl_chg;
      2'b01:   edge_qual = lvl_chg & s;
      2'b10:   edge_qual = lvl_chg & ~s;
      default: edge_qual = 1'b0;
    endcase
  end

  // Register-file writes; a captured edge wins over a simultaneous clear.
  always_comb begin
    cfg_d     = cfg_q;
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (address == 2'd1)) cfg_d     = writedata[1:0];
    if (wr_en && (address == 2'd2)) irqmask_d = writedata[0];
    if (edge_qual) begin
      edgecap_d = 1'b1;
    end else if (wr_en && (address == 2'd3) && writedata[0]) begin
      edgecap_d = 1'b0;
    end
  end

  // All state registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      lvl_q     <= 1'b0;
      cnt_q     <= 16'd0;
      cfg_q     <= 2'b00;
      irqmask_q <= 1'b0;
      edgecap_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      lvl_q     <= lvl_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // Zero-wait-state read mux, decoded from address alone.
  always_comb begin
    readdata = 32'd0;
    unique case (address)
      2'd0:    readdata = {31'd0, lvl_q};
      2'd1:    readdata = {30'd0, cfg_q};
      2'd2:    readdata = {31'd0, irqmask_q};
      default: readdata = {31'd0, edgecap_q};
    endcase
  end

  // Level interrupt straight from registered state.
  always_comb begin
    irq = edgecap_q & irqmask_q;
  end

endmodule
`default_nettype wire
